// File: rtl/demux_seq_ctrl.sv
// demux_seq_ctrl: sequences a 1xN demux through unmasked channels with setup, dwell and gap phases
module demux_seq_ctrl #(
    parameter int n     = 3,
    parameter int DWELL = 4,
    parameter int GAP   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            mode,
    input  logic [n-1:0]    addr,
    input  logic [2**n-1:0] mask,
    input  logic            f_in,
    output logic            f,
    output logic            en,
    output logic [n-1:0]    s,
    output logic            busy,
    output logic            done
);
    localparam int CW = $clog2((DWELL > GAP ? DWELL : GAP) + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_DRIVE, ST_GAP, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [n-1:0]      s_q, s_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic [2**n-1:0]   mask_q, mask_d;
    logic              fl_q, fl_d;
    logic              f_q, f_d, en_q, en_d, busy_q, busy_d, done_q, done_d;
    logic [n:0]        first_t, next_t;
    logic              has_next;

    // Lowest set bit of m at or above lo, returned as {found, index}
    function automatic logic [n:0] first_from(input logic [2**n-1:0] m, input int lo);
        logic [n:0] r;
        r = '0;
        for (int i = 2**n - 1; i >= 0; i--)
            if (m[i] && i >= lo) r = {1'b1, n'(i)};
        return r;
    endfunction

    // Next-state and registered-output computation; outputs follow the next state
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        mask_d   = mask_q;
        fl_d     = fl_q;
        first_t  = mode ? {mask[addr], addr} : first_from(mask, 0);
        next_t   = first_from(mask_q, int'(s_q) + 1);
        has_next = !mode_q && next_t[n];
        case (state_q)
            ST_IDLE: if (start) begin
                mode_d  = mode;
                mask_d  = mask;
                fl_d    = f_in;
                state_d = first_t[n] ? ST_SETUP : ST_DONE;
                s_d     = first_t[n] ? first_t[n-1:0] : '0;
            end
            ST_SETUP: begin
                state_d = ST_DRIVE;
                cnt_d   = CW'(DWELL - 1);
            end
            ST_DRIVE: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else if (GAP > 0) begin
                    state_d = ST_GAP;
                    cnt_d   = CW'(GAP - 1);
                end else begin
                    state_d = has_next ? ST_SETUP : ST_DONE;
                    s_d     = has_next ? next_t[n-1:0] : s_q;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else begin
                    state_d = has_next ? ST_SETUP : ST_DONE;
                    s_d     = has_next ? next_t[n-1:0] : s_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
        if (state_d == ST_IDLE) begin
            s_d   = '0;
            cnt_d = '0;
        end
        en_d   = state_d == ST_DRIVE;
        busy_d = state_d != ST_IDLE;
        done_d = state_d == ST_DONE;
        f_d    = busy_d ? fl_d : 1'b0;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            mask_q  <= '0;
            fl_q    <= 1'b0;
            f_q     <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            fl_q    <= fl_d;
            f_q     <= f_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign f    = f_q;
    assign en   = en_q;
    assign s    = s_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
